// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between a seq_alu client and the ALU
interface seq_alu_if #(parameter int W = 8);
  logic start;
  logic [3:0] op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic updateFlags;
  logic [W-1:0] C;
  logic CO;
  logic OVF;
  logic N;
  logic Z;
  logic busy;
  logic done;
  modport master(output start, op, A, B, updateFlags, input C, CO, OVF, N, Z, busy, done);
  modport slave(input start, op, A, B, updateFlags, output C, CO, OVF, N, Z, busy, done);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: ALU with single-cycle arithmetic/logic ops and bit-serial shifts and shift-add multiply
module seq_alu #(parameter int W = 8) (
  input logic clk,
  input logic reset,
  seq_alu_if.slave bus
);
  localparam int LW = $clog2(W);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, nxt;
  logic [3:0] op_r;
  logic [W-1:0] a_r, p_hi, p_lo;
  logic uf_r;
  logic [LW:0] rem;
  logic accept, iter, arith, last, fire, cin, res_co, res_ovf, sh_out, wr_co, wr_ovf, wr_uf;
  logic [W-1:0] x, y, res, sh_v, wr_c;
  logic [W:0] sum, mac;
  logic [2*W-1:0] prod;
  always_comb begin
    accept = state != EXEC && bus.start;
    iter = bus.op inside {[4'd9:4'd12]};
    arith = bus.op <= 4'd2 || bus.op == 4'd8;
    // subtraction is minuend + ~subtrahend + 1, so one adder serves ADD/SUB/RSB/ADC
    x = bus.op == 4'd2 ? bus.B : bus.A;
    y = bus.op == 4'd1 ? ~bus.B : bus.op == 4'd2 ? ~bus.A : bus.B;
    cin = bus.op == 4'd1 || bus.op == 4'd2 || (bus.op == 4'd8 && bus.CO);
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    res = arith ? sum[W-1:0] : bus.op == 4'd3 ? bus.A ^ bus.B : bus.op == 4'd4 ? bus.A & bus.B :
          bus.op == 4'd5 ? bus.A | bus.B : bus.op == 4'd6 ? bus.B : bus.A;
    res_co = arith && sum[W];
    res_ovf = arith && x[W-1] == y[W-1] && sum[W-1] != x[W-1];
    sh_v = op_r == 4'd9 ? {p_lo[W-2:0], 1'b0} : {op_r == 4'd11 && p_lo[W-1], p_lo[W-1:1]};
    sh_out = op_r == 4'd9 ? p_lo[W-1] : p_lo[0];
    // multiplier sits in p_lo and drains out as the product shifts in from the top
    mac = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_r} : '0);
    prod = {mac, p_lo[W-1:1]};
    last = state == EXEC && rem[LW:1] == '0;
    fire = last || (accept && !iter);
    wr_c = state != EXEC ? res : op_r == 4'd12 ? prod[W-1:0] : rem != '0 ? sh_v : p_lo;
    wr_co = state != EXEC ? res_co : op_r == 4'd12 ? |prod[2*W-1:W] : rem != '0 && sh_out;
    wr_ovf = state != EXEC ? res_ovf : op_r == 4'd12 && |prod[2*W-1:W];
    wr_uf = state == EXEC ? uf_r : bus.updateFlags;
    nxt = last ? DONE : state == EXEC ? EXEC : accept ? (iter ? EXEC : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.C <= '0;
      bus.CO <= 1'b0;
      bus.OVF <= 1'b0;
      bus.N <= 1'b0;
      bus.Z <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      if (fire) begin
        bus.C <= wr_c;
        if (wr_uf) begin
          bus.CO <= wr_co;
          bus.OVF <= wr_ovf;
          bus.N <= wr_c[W-1];
          bus.Z <= wr_c == '0;
        end
      end
      if (state == EXEC) begin
        rem <= rem - 1'b1;
        p_lo <= op_r == 4'd12 ? prod[W-1:0] : sh_v;
        p_hi <= prod[2*W-1:W];
      end else if (accept) begin
        op_r <= bus.op;
        a_r <= bus.A;
        uf_r <= bus.updateFlags;
        p_lo <= bus.op == 4'd12 ? bus.B : bus.A;
        p_hi <= '0;
        rem <= bus.op == 4'd12 ? (LW + 1)'(W) : {1'b0, bus.B[LW-1:0]};
      end
      state <= nxt;
      bus.busy <= nxt == EXEC;
      bus.done <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed table, corner sequences and random ops against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;
  localparam int H = 1 << (W - 1);
  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic uf;
    logic [W-1:0] c;
    logic [3:0] f;
    int lat;
  } vec_t;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_c;
  logic m_co, m_ovf, m_n, m_z;
  seq_alu_if #(.W(W)) bus();
  seq_alu #(.W(W)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit oor(input int v);
    return v > H - 1 || v < -H;
  endfunction
  function automatic logic [W+1:0] ref_op(input int o, input int ua, input int ub, input int cin);
    int sa, sb, r, n;
    logic co, ov;
    sa = ua >= H ? ua - (1 << W) : ua;
    sb = ub >= H ? ub - (1 << W) : ub;
    n = ub % W;
    co = 0;
    ov = 0;
    case (o)
      0: begin r = ua + ub; co = r > M; ov = oor(sa + sb); end
      1: begin r = ua - ub; co = ua >= ub; ov = oor(sa - sb); end
      2: begin r = ub - ua; co = ub >= ua; ov = oor(sb - sa); end
      3: r = ua ^ ub;
      4: r = ua & ub;
      5: r = ua | ub;
      6: r = ub;
      8: begin r = ua + ub + cin; co = r > M; ov = oor(sa + sb + cin); end
      9: begin r = ua << n; co = n > 0 && ((ua >> (W - n)) & 1) == 1; end
      10: begin r = ua >> n; co = n > 0 && ((ua >> (n - 1)) & 1) == 1; end
      11: begin r = sa >>> n; co = n > 0 && ((ua >> (n - 1)) & 1) == 1; end
      12: begin r = ua * ub; co = r > M; ov = co; end
      default: r = ua;
    endcase
    return {co, ov, r[W-1:0]};
  endfunction
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic u, input bit poke, output int lat);
    @(negedge clk);
    bus.op = o;
    bus.A = a;
    bus.B = b;
    bus.updateFlags = u;
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.op = 4'($urandom);
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    bus.updateFlags = 1'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (poke && lat == 2) bus.start = 1;
      @(posedge clk);
      #1;
      bus.start = 0;
      lat++;
    end
  endtask
  task automatic chk(input string nm, input logic [W-1:0] c, input logic [3:0] f, input int lat, input int elat);
    checks++;
    if (bus.C !== c) begin
      errors++;
      $display("FAIL %s: C=%h expected %h", nm, bus.C, c);
    end
    checks++;
    if ({bus.CO, bus.OVF, bus.N, bus.Z} !== f) begin
      errors++;
      $display("FAIL %s: CO/OVF/N/Z=%b expected %b", nm, {bus.CO, bus.OVF, bus.N, bus.Z}, f);
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s: latency=%0d expected %0d", nm, lat, elat);
    end
  endtask
  initial begin
    vec_t tbl[14];
    int lat, elat, seen;
    logic [W+1:0] r;
    logic [3:0] o;
    logic [W-1:0] a, b;
    logic u;
    tbl[0] = '{4'h0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0110, 0};
    tbl[1] = '{4'h1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1001, 0};
    tbl[2] = '{4'h0, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1001, 0};
    tbl[3] = '{4'h8, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000, 0};
    tbl[4] = '{4'hB, 8'h80, 8'h03, 1'b1, 8'hF0, 4'b0010, 3};
    tbl[5] = '{4'h9, 8'h81, 8'h01, 1'b1, 8'h02, 4'b1000, 1};
    tbl[6] = '{4'hC, 8'h10, 8'h10, 1'b1, 8'h00, 4'b1101, 8};
    tbl[7] = '{4'hC, 8'h0F, 8'h03, 1'b1, 8'h2D, 4'b0000, 8};
    tbl[8] = '{4'h2, 8'h03, 8'h01, 1'b1, 8'hFE, 4'b0010, 0};
    tbl[9] = '{4'hA, 8'h81, 8'h08, 1'b1, 8'h81, 4'b0010, 1};
    tbl[10] = '{4'hB, 8'h81, 8'h0F, 1'b1, 8'hFF, 4'b0010, 7};
    tbl[11] = '{4'hF, 8'h5A, 8'h33, 1'b1, 8'h5A, 4'b0000, 0};
    tbl[12] = '{4'h3, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b0000, 0};
    tbl[13] = '{4'h1, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100, 0};
    bus.start = 0;
    bus.op = 0;
    bus.A = 0;
    bus.B = 0;
    bus.updateFlags = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.C, bus.CO, bus.OVF, bus.N, bus.Z, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset: outputs=%h expected 0", {bus.C, bus.CO, bus.OVF, bus.N, bus.Z, bus.busy, bus.done});
    end
    reset = 0;
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].uf, 0, lat);
      chk($sformatf("vec%0d", i), tbl[i].c, tbl[i].f, lat, tbl[i].lat);
    end
    do_op(4'hC, 8'h0F, 8'h03, 1'b1, 1, lat);
    chk("mul_ignore_start", 8'h2D, 4'b0000, lat, 8);
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.C !== 8'h2D) begin
      errors++;
      $display("FAIL mul_ignore_after: done=%b busy=%b C=%h expected 0 0 2d", bus.done, bus.busy, bus.C);
    end
    @(negedge clk);
    bus.op = 4'hC;
    bus.A = 8'h0F;
    bus.B = 8'h03;
    bus.updateFlags = 1;
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.C, bus.CO, bus.OVF, bus.N, bus.Z, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_in_exec: outputs=%h expected 0", {bus.C, bus.CO, bus.OVF, bus.N, bus.Z, bus.busy, bus.done});
    end
    reset = 0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort: done/busy seen %0d cycles expected 0", seen);
    end
    m_c = 0;
    {m_co, m_ovf, m_n, m_z} = 4'b0000;
    for (int k = 0; k < 300; k++) begin
      o = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      u = $urandom_range(0, 3) != 0;
      r = ref_op(int'(o), int'(a), int'(b), int'(m_co));
      elat = o == 4'hC ? W : (o >= 4'h9 && o <= 4'hB) ? ((int'(b) % W) > 0 ? int'(b) % W : 1) : 0;
      if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
      do_op(o, a, b, u, 0, lat);
      m_c = r[W-1:0];
      if (u) begin
        m_co = r[W+1];
        m_ovf = r[W];
        m_n = r[W-1];
        m_z = r[W-1:0] == 0;
      end
      chk($sformatf("rnd%0d op%h", k, o), m_c, {m_co, m_ovf, m_n, m_z}, lat, elat);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter W, default 8, datapath width; legal values are powers of two, 4 and above.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted on a rising edge while busy=0.
REQ-005 SHALL have port op  input  4  operation code, sampled at acceptance.
REQ-006 SHALL have ports A, B  input  W each  operands, sampled at acceptance.
REQ-007 SHALL have port updateFlags  input  1  flag-write enable, sampled at acceptance.
REQ-008 SHALL have port C  output  W  registered result.
REQ-009 SHALL have ports CO, OVF, N, Z  output  1 each  registered carry, overflow, negative and zero flags.
REQ-010 SHALL have port busy  output  1  high while an iterative op executes.
REQ-011 SHALL have port done  output  1  one-cycle pulse when C and the flags are updated.

Function
REQ-012 SHALL decode op as follows:
- 0000 ADD A+B
- 0001 SUB A-B
- 0010 SUB B-A
- 0011 XOR
- 0100 AND
- 0101 OR
- 0110 pass B
- 0111 pass A
- 1000 ADC, A+B+CO (current registered CO)
- 1001 LSL
- 1010 LSR
- 1011 ASR
- 1100 MUL, unsigned, low W bits
- 1101-1111 pass A
REQ-013 SHALL use n = B[log2(W)-1:0] as the shift amount, and SHALL use only that field.
REQ-014 SHALL latch op, A, B, updateFlags and CO at acceptance edge t0; later input changes SHALL have no effect on the running operation.
REQ-015 SHALL implement states IDLE, EXEC and DONE; busy=1 only in EXEC; done=1 only in DONE.
REQ-016 SHALL, for ops 0000-1000 and 1101-1111, go IDLE->DONE at t0, so that done is high in the cycle after t0.
REQ-017 SHALL, for shifts, go to EXEC at t0 and shift one bit per edge; done follows edge t0+max(n,1); n=0 SHALL take one EXEC cycle and return A unchanged.
REQ-018 SHALL, for MUL, go to EXEC at t0 and use shift-add, one multiplier bit per edge; done follows edge t0+W.
REQ-019 SHALL go DONE->IDLE unconditionally; start is also accepted while done=1 (DONE behaves as idle), giving back-to-back ops.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL hold C and the flags between done pulses.
REQ-022 SHALL write flags on the done edge only if the latched updateFlags=1; otherwise the flags SHALL be unchanged.
REQ-023 SHALL compute N as C[W-1] and Z as (C==0) for all ops.
REQ-024 SHALL compute CO and OVF for arithmetic ops as follows:
- ADD/ADC: CO = carry-out; OVF = operands share a sign that differs from C.
- SUB: CO = NOT borrow (minuend + ~subtrahend + 1); OVF = operand signs differ and C sign differs from the minuend.
REQ-025 SHALL compute CO and OVF for non-arithmetic ops as follows:
- Logic and pass ops: CO=0, OVF=0.
- Shifts: CO = last bit shifted out (0 when n=0); OVF=0.
- MUL: CO = OVF = 1 iff the high W bits of the 2W-bit product are nonzero.
REQ-026 SHALL perform ASR with sign-fill and LSR with zero-fill.

Reset
REQ-027 SHALL, on an edge with reset=1, force state=IDLE, C=0, CO=OVF=N=Z=0, busy=0, done=0.
REQ-028 SHALL give reset priority over start; reset during EXEC SHALL abort the op without a done pulse.
REQ-029 SHALL ensure no output is X after the first reset edge.

Verification (W=8)
REQ-030 SHALL pass: after reset, ADD A=0x7F B=0x01 updateFlags=1 -> done in the cycle after t0; C=0x80, N=1, OVF=1, CO=0, Z=0.
REQ-031 SHALL pass: SUB A=0x05 B=0x05 -> C=0x00, Z=1, CO=1, OVF=0; then ADD 0xFF+0x01 giving CO=1, followed back-to-back by ADC 0x00+0x00 -> C=0x01, CO=0.
REQ-032 SHALL pass: ASR A=0x80 B=0x03 -> busy for 3 cycles, done after edge t0+3, C=0xF0, N=1, CO=0; LSL A=0x81 B=0x01 -> C=0x02, CO=1.
REQ-033 SHALL pass: MUL A=0x10 B=0x10 -> busy for 8 cycles, done after edge t0+8, C=0x00, Z=1, CO=OVF=1; MUL 0x0F x 0x03 -> C=0x2D, CO=0.
REQ-034 SHALL pass: start pulsed during MUL EXEC -> ignored, result unchanged; updateFlags=0 XOR -> C updated, flags unchanged.
REQ-035 SHALL pass: reset asserted at the 3rd EXEC cycle of MUL -> next cycle busy=0, done=0, C=0, all flags 0, and no done pulse follows.
